// File: rtl/alu_mon_pkg.sv
// Shared definitions for the ALU mismatch monitor: FSM encoding, trigger pattern
// and record layout helpers.
package alu_mon_pkg;

  typedef enum logic [1:0] {
    StClean   = 2'd0,
    StSuspect = 2'd1,
    StAlarm   = 2'd2
  } mon_state_e;

  // Trigger pattern is all-ones operands with opcode 0; truncated to DATA_W at use.
  localparam logic [31:0] TRIG_A  = '1;
  localparam logic [31:0] TRIG_B  = '1;
  localparam logic [1:0]  TRIG_OP = 2'b00;

  // Record layout, MSB first: {vec_idx, a, b, op, y_clean, y_trojan}.
  function automatic int unsigned rec_width(int unsigned cnt_w, int unsigned data_w,
                                            int unsigned op_w);
    return cnt_w + 4 * data_w + op_w;
  endfunction

  function automatic int unsigned rec_idx_lsb(int unsigned data_w, int unsigned op_w);
    return 4 * data_w + op_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a pop frees a slot for a push in the same
// cycle even when full. Depth must be a power of two.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Zero when empty so the output is clean after reset/clear.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_mismatch_monitor.sv
// Two-stage checker comparing clean and Trojan ALU results: counts vectors, trigger
// hits and mismatches, logs mismatch records in a FIFO and raises a sticky alarm.
module alu_mismatch_monitor
  import alu_mon_pkg::*;
#(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned OP_W         = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned ALARM_THRESH = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               in_a,
  input  logic [DATA_W-1:0]               in_b,
  input  logic [OP_W-1:0]                 in_op,
  input  logic [DATA_W-1:0]               y_clean,
  input  logic [DATA_W-1:0]               y_trojan,
  output logic                            rec_valid,
  input  logic                            rec_ready,
  output logic [CNT_W+4*DATA_W+OP_W-1:0]  rec_data,
  output logic [CNT_W-1:0]                vec_count,
  output logic [CNT_W-1:0]                trig_count,
  output logic [CNT_W-1:0]                mis_count,
  output logic                            alarm,
  output logic                            overflow,
  output logic [1:0]                      state
);

  localparam int unsigned      RecW   = rec_width(CNT_W, DATA_W, OP_W);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] Thresh = CNT_W'(ALARM_THRESH);

  logic              srst;
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q, s1_yc_q, s1_yt_q;
  logic [OP_W-1:0]   s1_op_q;
  logic [CNT_W-1:0]  s1_idx_q;
  logic [CNT_W-1:0]  vec_cnt_q, trig_cnt_q, mis_cnt_q, mis_cnt_d;
  logic              overflow_q, alarm_q;
  mon_state_e        state_q, state_d;
  logic              mismatch, trigger, pop, fifo_full, fifo_empty;
  logic [RecW-1:0]   rec_wdata;

  assign srst = !rst_n || clear;

  // Stage 1: capture the vector and tag it with the current (saturating) count.
  always_ff @(posedge clk) begin
    if (srst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_yc_q    <= '0;
      s1_yt_q    <= '0;
      s1_idx_q   <= '0;
      vec_cnt_q  <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_op_q  <= in_op;
        s1_yc_q  <= y_clean;
        s1_yt_q  <= y_trojan;
        s1_idx_q <= vec_cnt_q;
        if (vec_cnt_q != CntMax) vec_cnt_q <= vec_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    mismatch  = s1_valid_q && ((s1_yc_q ^ s1_yt_q) != '0);
    trigger   = s1_valid_q && (s1_a_q == DATA_W'(TRIG_A)) && (s1_b_q == DATA_W'(TRIG_B)) &&
                (s1_op_q == OP_W'(TRIG_OP));
    mis_cnt_d = mis_cnt_q;
    if (mismatch && (mis_cnt_q != CntMax)) mis_cnt_d = mis_cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClean, StSuspect: begin
        if (mismatch) state_d = (mis_cnt_d >= Thresh) ? StAlarm : StSuspect;
      end
      StAlarm: state_d = StAlarm;
      default: state_d = StClean;
    endcase
  end

  // Stage 2: evaluate counts, overflow and FSM.
  always_ff @(posedge clk) begin
    if (srst) begin
      trig_cnt_q <= '0;
      mis_cnt_q  <= '0;
      overflow_q <= 1'b0;
      state_q    <= StClean;
      alarm_q    <= 1'b0;
    end else begin
      if (trigger && (trig_cnt_q != CntMax)) trig_cnt_q <= trig_cnt_q + 1'b1;
      mis_cnt_q <= mis_cnt_d;
      if (mismatch && fifo_full && !pop) overflow_q <= 1'b1;
      state_q <= state_d;
      alarm_q <= (state_d == StAlarm);
    end
  end

  assign rec_wdata = {s1_idx_q, s1_a_q, s1_b_q, s1_op_q, s1_yc_q, s1_yt_q};
  assign pop       = !fifo_empty && rec_ready;

  sync_fifo #(
    .Width (RecW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (clear),
    .push_i  (mismatch),
    .wdata_i (rec_wdata),
    .pop_i   (pop),
    .rdata_o (rec_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rec_valid  = !fifo_empty;
  assign vec_count  = vec_cnt_q;
  assign trig_count = trig_cnt_q;
  assign mis_count  = mis_cnt_q;
  assign alarm      = alarm_q;
  assign overflow   = overflow_q;
  assign state      = state_q;

endmodule

// File: tb/tb_alu_mismatch_monitor.sv
// Bench for alu_mismatch_monitor: default instance, ALARM_THRESH=3 instance and
// CNT_W=4 instance share stimulus; records are checked through a scoreboard queue.
module tb_alu_mismatch_monitor;

  logic       clk = 1'b0;
  logic       rst_n, clear, in_valid, rec_ready;
  logic [3:0] in_a, in_b, y_clean, y_trojan;
  logic [1:0] in_op;

  logic        d_rec_valid, d_alarm, d_overflow;
  logic [33:0] d_rec_data;
  logic [15:0] d_vec_count, d_trig_count, d_mis_count;
  logic [1:0]  d_state;

  logic        t_rec_valid, t_alarm, t_overflow;
  logic [33:0] t_rec_data;
  logic [15:0] t_vec_count, t_trig_count, t_mis_count;
  logic [1:0]  t_state;

  logic        c_rec_valid, c_alarm, c_overflow;
  logic [21:0] c_rec_data;
  logic [3:0]  c_vec_count, c_trig_count, c_mis_count;
  logic [1:0]  c_state;

  always #5 clk = ~clk;

  alu_mismatch_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .y_clean(y_clean), .y_trojan(y_trojan), .rec_valid(d_rec_valid),
    .rec_ready(rec_ready), .rec_data(d_rec_data), .vec_count(d_vec_count),
    .trig_count(d_trig_count), .mis_count(d_mis_count), .alarm(d_alarm),
    .overflow(d_overflow), .state(d_state)
  );

  alu_mismatch_monitor #(.ALARM_THRESH(3)) u_t3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .y_clean(y_clean), .y_trojan(y_trojan), .rec_valid(t_rec_valid),
    .rec_ready(rec_ready), .rec_data(t_rec_data), .vec_count(t_vec_count),
    .trig_count(t_trig_count), .mis_count(t_mis_count), .alarm(t_alarm),
    .overflow(t_overflow), .state(t_state)
  );

  alu_mismatch_monitor #(.CNT_W(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .y_clean(y_clean), .y_trojan(y_trojan), .rec_valid(c_rec_valid),
    .rec_ready(rec_ready), .rec_data(c_rec_data), .vec_count(c_vec_count),
    .trig_count(c_trig_count), .mis_count(c_mis_count), .alarm(c_alarm),
    .overflow(c_overflow), .state(c_state)
  );

  int          checks = 0;
  int          errors = 0;
  int          pop_cnt = 0;
  logic        sb_en = 1'b1;
  logic [33:0] sb[$];
  logic [33:0] last_rec = '0;

  typedef struct {
    logic [3:0] a, b;
    logic [1:0] op;
    logic [3:0] yc, yt;
    int         exp_trig;
    int         exp_mis;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                       input logic [3:0] yc, input logic [3:0] yt);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    y_clean  = yc;
    y_trojan = yt;
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    sb.delete();
    pop_cnt  = 0;
  endtask

  function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b,
                                     input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Compare the head record on the half-cycle before the edge that pops it.
  always @(negedge clk) begin
    if (sb_en && d_rec_valid && rec_ready) begin
      pop_cnt++;
      last_rec = d_rec_data;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rec_unexpected: got %0h expected none", d_rec_data);
      end else begin
        chk("rec_data", d_rec_data, sb.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          ct, cm, m, idx, es;
    logic [3:0]  yc, yt;
    logic        mis;
    logic [33:0] exp_rec;

    tbl[0] = '{4'hF, 4'hF, 2'd0, 4'hE, 4'hE, 1, 0};
    tbl[1] = '{4'h3, 4'h4, 2'd1, 4'hF, 4'hE, 0, 1};
    tbl[2] = '{4'hF, 4'hF, 2'd1, 4'h0, 4'h0, 0, 0};
    tbl[3] = '{4'hF, 4'hE, 2'd0, 4'hD, 4'h5, 0, 1};
    tbl[4] = '{4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 0, 0};
    tbl[5] = '{4'hF, 4'hF, 2'd0, 4'hE, 4'hF, 1, 1};

    // Reset, with a mismatching vector presented while in reset.
    rst_n = 1'b0; clear = 1'b0; rec_ready = 1'b0;
    drive(4'h1, 4'h2, 2'd0, 4'h3, 4'h4);
    step(); step();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst_vec", d_vec_count, 0);
    chk("rst_trig", d_trig_count, 0);
    chk("rst_mis", d_mis_count, 0);
    chk("rst_rec_valid", d_rec_valid, 0);
    chk("rst_rec_data", d_rec_data, 0);
    chk("rst_state", d_state, 0);
    chk("rst_alarm", d_alarm, 0);
    chk("rst_overflow", d_overflow, 0);
    step(); step();
    chk("rst_after_mis", d_mis_count, 0);
    chk("rst_after_rec", d_rec_valid, 0);

    // Table-driven single vectors.
    do_clear();
    rec_ready = 1'b1; ct = 0; cm = 0;
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].yc, tbl[i].yt);
      if (tbl[i].exp_mis != 0)
        sb.push_back({16'(i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].yc, tbl[i].yt});
      step(); in_valid = 1'b0; step(); step();
      ct += tbl[i].exp_trig;
      cm += tbl[i].exp_mis;
      chk("tbl_vec", d_vec_count, i + 1);
      chk("tbl_trig", d_trig_count, ct);
      chk("tbl_mis", d_mis_count, cm);
      chk("tbl_alarm", d_alarm, (cm >= 1) ? 1 : 0);
    end
    chk("tbl_sb_drained", sb.size(), 0);

    // Exhaustive sweep with the trigger-flip Trojan.
    do_clear();
    rec_ready = 1'b1; idx = 0;
    for (int op = 0; op < 4; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          yc = alu(4'(a), 4'(b), 2'(op));
          yt = (a == 15 && b == 15 && op == 0) ? (yc ^ 4'h1) : yc;
          drive(4'(a), 4'(b), 2'(op), yc, yt);
          if (yt != yc) sb.push_back({16'(idx), 4'(a), 4'(b), 2'(op), yc, yt});
          step();
          idx++;
        end
    in_valid = 1'b0; step(); step();
    exp_rec = {16'h00FF, 4'hF, 4'hF, 2'b00, 4'hE, 4'hF};
    chk("exh_vec", d_vec_count, 1024);
    chk("exh_trig", d_trig_count, 1);
    chk("exh_mis", d_mis_count, 1);
    chk("exh_alarm", d_alarm, 1);
    chk("exh_state", d_state, 2);
    chk("exh_pops", pop_cnt, 1);
    chk("exh_record", last_rec, exp_rec);

    // ALARM_THRESH=3: mismatches at vectors 5, 9 and 20.
    do_clear();
    sb_en = 1'b0; rec_ready = 1'b1; m = 0;
    for (int k = 0; k < 25; k++) begin
      mis = (k == 5 || k == 9 || k == 20);
      drive(4'(k), 4'h1, 2'd2, 4'h2, mis ? 4'h3 : 4'h2);
      step();
      es = (m >= 3) ? 2 : ((m >= 1) ? 1 : 0);
      chk("t3_state", t_state, es);
      chk("t3_alarm", t_alarm, (es == 2) ? 1 : 0);
      if (mis) m++;
    end
    sb_en = 1'b1;

    // Overflow: ten mismatches with the consumer stalled.
    do_clear();
    rec_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(4'(k), 4'h0, 2'd3, 4'(k), ~4'(k));
      if (k < 8) sb.push_back({16'(k), 4'(k), 4'h0, 2'd3, 4'(k), ~4'(k)});
      step();
    end
    in_valid = 1'b0; step(); step();
    chk("ovf_mis", d_mis_count, 10);
    chk("ovf_flag", d_overflow, 1);
    chk("ovf_rec_valid", d_rec_valid, 1);
    rec_ready = 1'b1;
    repeat (8) step();
    rec_ready = 1'b0;
    chk("ovf_pops", pop_cnt, 8);
    chk("ovf_sb_drained", sb.size(), 0);
    chk("ovf_empty", d_rec_valid, 0);

    // Full FIFO with push and pop on the same edge.
    do_clear();
    rec_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive(4'(k), 4'h5, 2'd2, 4'h1, 4'h0);
      sb.push_back({16'(k), 4'(k), 4'h5, 2'd2, 4'h1, 4'h0});
      step();
    end
    in_valid = 1'b0; rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
    chk("fp_overflow", d_overflow, 0);
    chk("fp_mis", d_mis_count, 9);
    chk("fp_pops", pop_cnt, 1);
    rec_ready = 1'b1;
    repeat (8) step();
    rec_ready = 1'b0;
    chk("fp_level_pops", pop_cnt, 9);
    chk("fp_sb_drained", sb.size(), 0);
    chk("fp_empty", d_rec_valid, 0);

    // Clear while a mismatch sits in stage 1 and another is presented.
    do_clear();
    rec_ready = 1'b1;
    drive(4'h1, 4'h2, 2'd0, 4'h3, 4'h4);
    step();
    clear = 1'b1;
    drive(4'h5, 4'h6, 2'd0, 4'h7, 4'h8);
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_vec", d_vec_count, 0);
    chk("clr_mis", d_mis_count, 0);
    chk("clr_trig", d_trig_count, 0);
    chk("clr_rec_valid", d_rec_valid, 0);
    chk("clr_state", d_state, 0);
    step(); step();
    chk("clr_later_rec", d_rec_valid, 0);
    chk("clr_later_mis", d_mis_count, 0);
    chk("clr_later_pops", pop_cnt, 0);

    // Saturation with CNT_W=4.
    do_clear();
    sb_en = 1'b0; rec_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(4'(k), 4'h2, 2'd2, 4'h0, 4'h8);
      step();
      chk("c4_vec", c_vec_count, (k + 1 > 15) ? 15 : k + 1);
      if (k >= 1) chk("c4_idx", c_rec_data[21:18], (k - 1 > 15) ? 15 : k - 1);
    end
    in_valid = 1'b0; step(); step();
    chk("c4_vec_final", c_vec_count, 15);
    chk("c4_mis_sat", c_mis_count, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mismatch_monitor.md
Name: alu_mismatch_monitor

Overview:
- Synthesizable clocked checker for the side-channel analysis path. It receives vectors applied to the clean and Trojan ALU pair (A, B, op) together with both ALU results.
- It counts vectors, counts trigger-pattern hits and counts output mismatches.
- It buffers one record per mismatch in a small FIFO, read out over a valid/ready port.
- It raises a sticky alarm once a mismatch threshold is reached.

Parameters:
- DATA_W, 4, operand/result width.
- OP_W, 2, opcode width.
- CNT_W, 16, width of all counters, including the vector index.
- FIFO_DEPTH, 8, number of mismatch records held (power of 2).
- ALARM_THRESH, 1, mismatch count at which the FSM enters ALARM (1..2^CNT_W-1).

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, synchronous active-low reset.
- clear, in, 1, synchronous soft clear of all state (same effect as reset).
- in_valid, in, 1, the vector on in_a/in_b/in_op/y_clean/y_trojan is valid this cycle.
- in_a, in, DATA_W, operand A.
- in_b, in, DATA_W, operand B.
- in_op, in, OP_W, opcode.
- y_clean, in, DATA_W, clean ALU result.
- y_trojan, in, DATA_W, Trojan ALU result.
- rec_valid, out, 1, FIFO head record valid.
- rec_ready, in, 1, consumer accepts the head record.
- rec_data, out, CNT_W+3*DATA_W+OP_W+DATA_W, fields {vec_idx, a, b, op, y_clean, y_trojan}, MSB first.
- vec_count, out, CNT_W, vectors accepted.
- trig_count, out, CNT_W, vectors with A=all-ones, B=all-ones, op=0.
- mis_count, out, CNT_W, vectors with y_clean != y_trojan.
- alarm, out, 1, high while the FSM is in ALARM.
- overflow, out, 1, sticky: a mismatch record was dropped because the FIFO was full.
- state, out, 2, FSM state encoding.

Behaviour:
- Reset (rst_n=0 at an edge) and clear=1 have identical effect:
  - All counters 0, FIFO empty, rec_valid=0, rec_data=0.
  - alarm=0, overflow=0, stage-1 valid=0, state=CLEAN.
  - Any in-flight vector is discarded. Clear beats in_valid in the same cycle.
- Stage 1 (capture): at an edge with in_valid=1, register all inputs. Tag the vector with vec_idx equal to the current vector count, then increment the internal vector count.
- Stage 2 (evaluate): at the next edge, for the registered vector:
  - Compute mismatch = (y_clean XOR y_trojan) != 0.
  - Compute trigger = (a==all-ones && b==all-ones && op==0).
  - Update trig_count and mis_count, and push a record on mismatch.
  - Result latency: counts/record are visible 2 edges after the capture edge. vec_count is visible 1 edge after.
- One vector per cycle, no backpressure on input; in_valid may be held high continuously.
- Counters saturate at 2^CNT_W-1, never wrap. vec_idx saturates the same way.
- FIFO:
  - Push when a mismatch is evaluated and the FIFO is not full. If full and no pop occurs that cycle, drop the record, set overflow, and still increment mis_count.
  - Push and pop in the same cycle while full: the pop frees a slot and the push is accepted.
  - Pop at an edge with rec_valid && rec_ready. rec_ready while empty is ignored.
  - rec_data holds the head record while rec_valid=1 and rec_ready=0.
  - rec_data shows first-word-fall-through: the head is valid the edge after the push.
- FSM (evaluated at stage 2):
  - CLEAN(0) -> SUSPECT(1) on the first mismatch when ALARM_THRESH>1.
  - CLEAN/SUSPECT -> ALARM(2) when the updated mis_count >= ALARM_THRESH.
  - ALARM is terminal until reset/clear.
  - Encoding 3 is unused; if entered, return to CLEAN.
  - alarm = (state==ALARM), registered.

Decomposition:
- Shared include/package alu_mon_pkg:
  - State encodings CLEAN/SUSPECT/ALARM.
  - Record field offsets/widths.
  - Trigger pattern constants (TRIG_A=4'hF, TRIG_B=4'hF, TRIG_OP=2'b00).
- One natural sub-module: sync_fifo (parameterized width/depth, first-word-fall-through, full/empty, same-cycle push/pop).

Test Plan:
- Reset then 1024 exhaustive vectors, Trojan model = clean except result^4'b0001 on the trigger pattern:
  - vec_count=1024, trig_count=1, mis_count=1, one record with vec_idx=0x0FF, a=F, b=F, op=0, y_trojan=y_clean^1.
  - alarm=1 (THRESH=1).
- ALARM_THRESH=3, three mismatches at vectors 5, 9, 20:
  - state CLEAN->SUSPECT two edges after vector 5's capture edge.
  - ALARM two edges after vector 20's capture edge.
- rec_ready=0, 10 consecutive mismatching vectors, FIFO_DEPTH=8:
  - 8 records stored, overflow=1, mis_count=10.
  - Draining yields vec_idx 0..7 in order.
- FIFO full, a mismatch evaluated in the same cycle as rec_ready=1: the record is accepted, overflow stays 0, level stays 8.
- clear=1 asserted with in_valid=1 while a mismatch is in stage 1:
  - Next cycle all counts are 0, rec_valid=0, state=CLEAN.
  - No record appears afterwards.
- Force vec_count near saturation (CNT_W=4, 20 vectors): vec_count holds at 15 and vec_idx of later records is 15.
